// File: rtl/gauss_seq_pkg.sv
// Shared types and default geometry for the Gaussian frame sequencer.
// Imported by the sequencer top and the address counter.
package gauss_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS,
    RUN,
    GAP,
    DRAIN,
    DONE
  } seq_state_e;

  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_ADDR_W   = 17;
  localparam int FRAME_PIX    = DEF_H_ACTIVE * DEF_V_ACTIVE;

  function automatic int frame_pix(input int h_active, input int v_active);
    return h_active * v_active;
  endfunction

endpackage

// File: rtl/gauss_frame_sequencer_if.sv
// Control, frame-buffer and write-back signals of the Gaussian frame sequencer.
// Defining GAUSS_SEQ_STATS_EN adds the ready_cnt / cnt_mismatch statistics signals.
interface gauss_frame_sequencer_if #(
  parameter int ADDR_W = gauss_seq_pkg::DEF_ADDR_W
);

  logic              start;
  logic              continuous;
  logic              abort;
  logic              vsync_in;
  logic              filt_ready_in;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic              filt_enable;
  logic              filt_active;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              busy;
  logic              frame_done;
  logic              frame_err;
`ifdef GAUSS_SEQ_STATS_EN
  logic [ADDR_W:0]   ready_cnt;
  logic              cnt_mismatch;

  modport master (
    input  start, continuous, abort, vsync_in, filt_ready_in,
    output rd_addr, rd_en, filt_enable, filt_active, wr_addr, wr_en,
    output busy, frame_done, frame_err, ready_cnt, cnt_mismatch
  );

  modport slave (
    output start, continuous, abort, vsync_in, filt_ready_in,
    input  rd_addr, rd_en, filt_enable, filt_active, wr_addr, wr_en,
    input  busy, frame_done, frame_err, ready_cnt, cnt_mismatch
  );
`else
  modport master (
    input  start, continuous, abort, vsync_in, filt_ready_in,
    output rd_addr, rd_en, filt_enable, filt_active, wr_addr, wr_en,
    output busy, frame_done, frame_err
  );

  modport slave (
    output start, continuous, abort, vsync_in, filt_ready_in,
    input  rd_addr, rd_en, filt_enable, filt_active, wr_addr, wr_en,
    input  busy, frame_done, frame_err
  );
`endif

endinterface

// File: rtl/gauss_seq_addr_ctr.sv
// Loadable address counter that wraps from WRAP_AT-1 back to 0.
// Priority: clear, then load, then increment.
module gauss_seq_addr_ctr
  import gauss_seq_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int WRAP_AT = FRAME_PIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clr) begin
      addr_d = '0;
    end else if (load) begin
      addr_d = load_val;
    end else if (inc) begin
      addr_d = (addr_q == ADDR_W'(WRAP_AT - 1)) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/gauss_frame_sequencer.sv
// Frame sequencer driving the 3x3 Gaussian filter: read addressing, line gaps, drain, write-back.
// Optional statistics (ready_cnt, cnt_mismatch) are built when GAUSS_SEQ_STATS_EN is defined.
module gauss_frame_sequencer
  import gauss_seq_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LINE_GAP  = 4,
  parameter int DRAIN_CYC = 8
) (
  input logic clk,
  input logic rst,
  gauss_frame_sequencer_if.master bus
);

  localparam int PIX_TOTAL = frame_pix(H_ACTIVE, V_ACTIVE);
  localparam int COL_W     = $clog2(H_ACTIVE + 1);
  localparam int ROW_W     = $clog2(V_ACTIVE + 1);
  localparam int GAP_W     = $clog2(LINE_GAP + 1);
  localparam int DRN_W     = $clog2(DRAIN_CYC + 1);

  seq_state_e       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [DRN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             vsync_prev_q;
  logic             rd_en_q, rd_en_d;
  logic             filt_active_q, filt_active_d;
  logic             busy_q, busy_d;
  logic             wr_en_q, wr_en_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic             vs_edge;
  logic             rd_clr, rd_inc, wr_clr;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  // A vsync edge while the frame is still being read restarts the frame from pixel 0.
  always_comb begin
    vs_edge      = bus.vsync_in & ~vsync_prev_q;
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    gap_cnt_d    = gap_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    rd_clr       = 1'b0;
    rd_inc       = 1'b0;
    wr_clr       = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_edge) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
          rd_clr  = 1'b1;
          wr_clr  = 1'b1;
        end
      end
      RUN, GAP: begin
        if (vs_edge) begin
          state_d     = RUN;
          col_d       = '0;
          row_d       = '0;
          gap_cnt_d   = '0;
          rd_clr      = 1'b1;
          wr_clr      = 1'b1;
          frame_err_d = 1'b1;
        end else if (state_q == RUN) begin
          rd_inc = 1'b1;
          if (col_q == COL_W'(H_ACTIVE - 1)) begin
            col_d = '0;
            if (row_q == ROW_W'(V_ACTIVE - 1)) begin
              state_d     = DRAIN;
              drain_cnt_d = '0;
            end else begin
              state_d   = GAP;
              row_d     = row_q + ROW_W'(1);
              gap_cnt_d = '0;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else if (gap_cnt_q == GAP_W'(LINE_GAP - 1)) begin
          state_d = RUN;
          col_d   = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRN_W'(DRAIN_CYC - 1)) begin
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRN_W'(1);
        end
      end
      DONE: begin
        state_d = bus.continuous ? WAIT_VS : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      state_d     = IDLE;
      col_d       = '0;
      row_d       = '0;
      gap_cnt_d   = '0;
      drain_cnt_d = '0;
      rd_clr      = 1'b1;
      wr_clr      = 1'b1;
      frame_err_d = 1'b0;
    end

    busy_d        = (state_d != IDLE);
    rd_en_d       = (state_d == RUN);
    filt_active_d = (state_d == RUN);
    frame_done_d  = (state_d == DONE);
    wr_en_d       = bus.filt_ready_in & busy_d;
  end

`ifdef GAUSS_SEQ_STATS_EN
  logic [ADDR_W:0] ready_cnt_q, ready_cnt_d;
  logic            cnt_mismatch_q, cnt_mismatch_d;

  // Counting stops at DONE so the final count stays visible until the next frame starts.
  always_comb begin
    ready_cnt_d = ready_cnt_q;
    if ((state_q == WAIT_VS && state_d == RUN) || frame_err_d) begin
      ready_cnt_d = '0;
    end else if (bus.filt_ready_in &&
                 (state_q == RUN || state_q == GAP || state_q == DRAIN)) begin
      ready_cnt_d = ready_cnt_q + (ADDR_W + 1)'(1);
    end
    cnt_mismatch_d = (state_d == DONE) && (ready_cnt_d != (ADDR_W + 1)'(PIX_TOTAL));
  end

  assign bus.ready_cnt    = ready_cnt_q;
  assign bus.cnt_mismatch = cnt_mismatch_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      col_q          <= '0;
      row_q          <= '0;
      gap_cnt_q      <= '0;
      drain_cnt_q    <= '0;
      vsync_prev_q   <= 1'b0;
      rd_en_q        <= 1'b0;
      filt_active_q  <= 1'b0;
      busy_q         <= 1'b0;
      wr_en_q        <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_err_q    <= 1'b0;
`ifdef GAUSS_SEQ_STATS_EN
      ready_cnt_q    <= '0;
      cnt_mismatch_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      gap_cnt_q      <= gap_cnt_d;
      drain_cnt_q    <= drain_cnt_d;
      vsync_prev_q   <= bus.vsync_in;
      rd_en_q        <= rd_en_d;
      filt_active_q  <= filt_active_d;
      busy_q         <= busy_d;
      wr_en_q        <= wr_en_d;
      frame_done_q   <= frame_done_d;
      frame_err_q    <= frame_err_d;
`ifdef GAUSS_SEQ_STATS_EN
      ready_cnt_q    <= ready_cnt_d;
      cnt_mismatch_q <= cnt_mismatch_d;
`endif
    end
  end

  gauss_seq_addr_ctr #(
    .ADDR_W (ADDR_W),
    .WRAP_AT(PIX_TOTAL)
  ) u_rd_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (rd_clr),
    .load    (1'b0),
    .load_val('0),
    .inc     (rd_inc),
    .addr    (rd_addr)
  );

  // The write address advances after each registered write strobe.
  gauss_seq_addr_ctr #(
    .ADDR_W (ADDR_W),
    .WRAP_AT(PIX_TOTAL)
  ) u_wr_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr     (wr_clr),
    .load    (1'b0),
    .load_val('0),
    .inc     (wr_en_q),
    .addr    (wr_addr)
  );

  assign bus.rd_addr     = rd_addr;
  assign bus.wr_addr     = wr_addr;
  assign bus.rd_en       = rd_en_q;
  assign bus.filt_active = filt_active_q;
  assign bus.filt_enable = busy_q;
  assign bus.busy        = busy_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_gauss_frame_sequencer.sv
// Directed self-checking bench for gauss_frame_sequencer on an 8x4 frame.
// Statistics checks are compiled in when GAUSS_SEQ_STATS_EN is defined.
module tb_gauss_frame_sequencer;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int LGAP  = 2;
  localparam int DRAIN = 3;
  localparam int AW    = 17;
  localparam int PIX   = H * V;

  logic clk = 1'b0;
  logic rst;

  gauss_frame_sequencer_if #(.ADDR_W(AW)) bus ();

  gauss_frame_sequencer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW),
    .LINE_GAP (LGAP),
    .DRAIN_CYC(DRAIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   checkCount = 0;
  int   passCount  = 0;
  int   doneCyc;
  int   lineIdx;
  int   posIdx;
  int   cycles;
  int   errs;
  logic expRun;
  bit   found;

  // Every comparison of the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic c, input logic a,
                               input logic v, input logic r);
    bus.start         = s;
    bus.continuous    = c;
    bus.abort         = a;
    bus.vsync_in      = v;
    bus.filt_ready_in = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse, then a vsync edge; returns on the first RUN cycle.
  task automatic beginFrame(input logic cont);
    applyStimulus(1'b1, cont, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, cont, 1'b0, 1'b1, 1'b0);
    tick();
    bus.vsync_in = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cyc, output int nerr);
    cyc  = 0;
    nerr = 0;
    do begin
      tick();
      cyc++;
      if (bus.frame_err) nerr++;
    end while (!bus.frame_done && cyc < budget);
    if (!bus.frame_done) cyc = -1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_busy",        32'(bus.busy), 0);
    checkOutput("reset_rd_en",       32'(bus.rd_en), 0);
    checkOutput("reset_rd_addr",     32'(bus.rd_addr), 0);
    checkOutput("reset_wr_addr",     32'(bus.wr_addr), 0);
    checkOutput("reset_wr_en",       32'(bus.wr_en), 0);
    checkOutput("reset_filt_enable", 32'(bus.filt_enable), 0);
    checkOutput("reset_filt_active", 32'(bus.filt_active), 0);
    checkOutput("reset_frame_done",  32'(bus.frame_done), 0);
    checkOutput("reset_frame_err",   32'(bus.frame_err), 0);
    rst = 1'b0;
    tick();

    $display("[TB] full frame sequencing");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("wait_vs_busy",  32'(bus.busy), 1);
    checkOutput("wait_vs_rd_en", 32'(bus.rd_en), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("wait_vs_hold", 32'(bus.busy), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    doneCyc = 0;
    errs    = 0;
    for (int c = 1; c <= 60 && doneCyc == 0; c++) begin
      tick();
      if (c == 1) bus.vsync_in = 1'b0;
      lineIdx = (c - 1) / (H + LGAP);
      posIdx  = (c - 1) % (H + LGAP);
      expRun  = (lineIdx < V) && (posIdx < H);
      checkOutput("frame_rd_en",       32'(bus.rd_en), 32'(expRun));
      checkOutput("frame_filt_active", 32'(bus.filt_active), 32'(expRun));
      if (expRun) checkOutput("frame_rd_addr", 32'(bus.rd_addr), lineIdx * H + posIdx);
      if (bus.frame_err) errs++;
      if (bus.frame_done) doneCyc = c;
    end
    checkOutput("frame_done_cycle", doneCyc, 42);
    checkOutput("frame_no_err", errs, 0);
    tick();
    checkOutput("frame_idle_busy",  32'(bus.busy), 0);
    checkOutput("frame_done_pulse", 32'(bus.frame_done), 0);

    $display("[TB] write-back wrap");
    beginFrame(1'b0);
    checkOutput("wb_start_addr", 32'(bus.wr_addr), 0);
    bus.filt_ready_in = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      tick();
      checkOutput("wb_wr_en",   32'(bus.wr_en), 1);
      checkOutput("wb_wr_addr", 32'(bus.wr_addr), (k - 1) % PIX);
    end
    bus.filt_ready_in = 1'b0;
    tick();
    checkOutput("wb_wr_en_off",   32'(bus.wr_en), 0);
    checkOutput("wb_wr_addr_end", 32'(bus.wr_addr), 2);
    waitDone(60, cycles, errs);
    checkOutput("wb_done_seen", 32'(bus.frame_done), 1);
    tick();

    $display("[TB] vsync mid-frame");
    beginFrame(1'b0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (bus.rd_en && bus.rd_addr == AW'(2 * H + 5)) found = 1'b1;
    end
    checkOutput("err_reach_r2c5", 32'(found), 1);
    bus.vsync_in = 1'b1;
    tick();
    bus.vsync_in = 1'b0;
    checkOutput("err_pulse",        32'(bus.frame_err), 1);
    checkOutput("err_restart_addr", 32'(bus.rd_addr), 0);
    checkOutput("err_restart_rd",   32'(bus.rd_en), 1);
    tick();
    checkOutput("err_pulse_once", 32'(bus.frame_err), 0);
    checkOutput("err_next_addr",  32'(bus.rd_addr), 1);
    waitDone(80, cycles, errs);
    checkOutput("err_done_cycles", cycles, 40);
    checkOutput("err_no_more",     errs, 0);
    tick();

    $display("[TB] abort handling");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("abort_wait_busy", 32'(bus.busy), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_busy",        32'(bus.busy), 0);
    checkOutput("abort_filt_enable", 32'(bus.filt_enable), 0);
    checkOutput("abort_no_done",     32'(bus.frame_done), 0);
    tick();
    checkOutput("abort_stays_idle", 32'(bus.busy), 0);
    beginFrame(1'b0);
    bus.filt_ready_in = 1'b1;
    tick();
    tick();
    checkOutput("abort_run_rd_en", 32'(bus.rd_en), 1);
    bus.abort = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_run_rd_drop", 32'(bus.rd_en), 0);
    checkOutput("abort_run_wr_drop", 32'(bus.wr_en), 0);
    checkOutput("abort_run_busy",    32'(bus.busy), 0);
    checkOutput("abort_run_no_done", 32'(bus.frame_done), 0);
    tick();

    $display("[TB] asynchronous reset mid-frame");
    beginFrame(1'b0);
    bus.filt_ready_in = 1'b1;
    tick();
    tick();
    checkOutput("rst_pre_rd_addr", 32'(bus.rd_addr), 2);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_rd_en",   32'(bus.rd_en), 0);
    checkOutput("rst_async_rd_addr", 32'(bus.rd_addr), 0);
    checkOutput("rst_async_wr_en",   32'(bus.wr_en), 0);
    checkOutput("rst_async_wr_addr", 32'(bus.wr_addr), 0);
    checkOutput("rst_async_busy",    32'(bus.busy), 0);
    checkOutput("rst_async_active",  32'(bus.filt_active), 0);
    bus.filt_ready_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_release_busy", 32'(bus.busy), 0);
    bus.vsync_in = 1'b1;
    tick();
    tick();
    checkOutput("rst_idle_ignores_vsync", 32'(bus.busy), 0);
    bus.vsync_in = 1'b0;
    tick();

    $display("[TB] continuous mode");
    beginFrame(1'b1);
    bus.filt_ready_in = 1'b1;
    repeat (32) tick();
    bus.filt_ready_in = 1'b0;
    waitDone(60, cycles, errs);
    checkOutput("cont_done1", 32'(bus.frame_done), 1);
`ifdef GAUSS_SEQ_STATS_EN
    checkOutput("stats_cnt_full",      32'(bus.ready_cnt), PIX);
    checkOutput("stats_no_mismatch",   32'(bus.cnt_mismatch), 0);
`endif
    tick();
    checkOutput("cont_rearm_busy",  32'(bus.busy), 1);
    checkOutput("cont_rearm_rd_en", 32'(bus.rd_en), 0);
    bus.vsync_in = 1'b1;
    tick();
    bus.vsync_in = 1'b0;
    checkOutput("cont_f2_rd_en",   32'(bus.rd_en), 1);
    checkOutput("cont_f2_rd_addr", 32'(bus.rd_addr), 0);
    checkOutput("cont_f2_no_err",  32'(bus.frame_err), 0);
    bus.filt_ready_in = 1'b1;
    repeat (31) tick();
    bus.filt_ready_in = 1'b0;
    waitDone(60, cycles, errs);
    checkOutput("cont_done2", 32'(bus.frame_done), 1);
`ifdef GAUSS_SEQ_STATS_EN
    checkOutput("stats_cnt_short", 32'(bus.ready_cnt), 31);
    checkOutput("stats_mismatch",  32'(bus.cnt_mismatch), 1);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("cont_abort_busy", 32'(bus.busy), 0);
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/gauss_frame_sequencer.md
Name: gauss_frame_sequencer

Overview:
Sequences the 3x3 grayscale Gaussian filter over one frame held in the 320x240 8-bit frame buffer.
- Generates frame-buffer read addresses and the filter's enable/active-area controls, line by line, with inter-line gaps.
- Generates write-back addresses for filtered pixels from the filter's ready strobe.
- Sits between the camera capture/frame-buffer logic and the filter; the filter's pixel_addr input is driven from rd_addr.

Parameters:
- H_ACTIVE, 320, pixels per line.
- V_ACTIVE, 240, lines per frame.
- ADDR_W, 17, frame-buffer address width; H_ACTIVE*V_ACTIVE must be at most 2^ADDR_W.
- LINE_GAP, 4, idle cycles between lines with filt_active low. Minimum 1.
- DRAIN_CYC, 8, cycles waited after the last read for the filter pipeline to empty.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to process one frame.
- continuous  in  1  when 1, re-arm automatically after each frame.
- abort  in  1  synchronous abort; forces IDLE next cycle.
- vsync_in  in  1  camera vsync, already synchronous to clk.
- filt_ready_in  in  1  filter output-valid strobe.
- rd_addr  out  ADDR_W  frame-buffer read address, also drives the filter's pixel_addr.
- rd_en  out  1  frame-buffer read strobe.
- filt_enable  out  1  filter enable.
- filt_active  out  1  filter active_area.
- wr_addr  out  ADDR_W  result-buffer write address.
- wr_en  out  1  result-buffer write strobe.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- frame_err  out  1  one-cycle pulse when vsync arrives mid-frame.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- States: IDLE, WAIT_VS, RUN, GAP, DRAIN, DONE.
- IDLE: when start=1, go to WAIT_VS.
- WAIT_VS: on the vsync_in rising edge (registered compare against the previous value), go to RUN with col=0, row=0, rd_addr=0, wr_addr=0.
- RUN: rd_en=1 and filt_active=1 every cycle. rd_addr increments by 1 per cycle; col counts 0..H_ACTIVE-1.
  - At col=H_ACTIVE-1 with row<V_ACTIVE-1: go to GAP and increment row.
  - At col=H_ACTIVE-1 with row=V_ACTIVE-1: go to DRAIN.
- GAP: rd_en=0 and filt_active=0 for exactly LINE_GAP cycles, then RUN with col=0. rd_addr holds across the gap, so addresses stay contiguous.
- DRAIN: filt_active=0 for DRAIN_CYC cycles, then DONE.
- DONE: frame_done=1 for one cycle. Next state is WAIT_VS if continuous=1, else IDLE.
- filt_enable = busy. All outputs are registered.
- Write-back:
  - wr_en = filt_ready_in registered, gated by busy.
  - wr_addr increments after each write.
  - wr_addr wraps from H_ACTIVE*V_ACTIVE-1 to 0; excess strobes overwrite from the start.
- Per-frame throughput: H_ACTIVE*V_ACTIVE reads in H_ACTIVE*V_ACTIVE + (V_ACTIVE-1)*LINE_GAP cycles.
- vsync rising edge in RUN or GAP:
  - pulse frame_err for one cycle;
  - restart at row 0, col 0, rd_addr 0, wr_addr 0, staying in RUN.
- vsync rising edge in DRAIN or DONE: ignored.
- abort: has priority over every transition. The next state is IDLE and all strobes drop on the next cycle; frame_done is not pulsed.
- start while busy: ignored.
- start and abort in the same cycle: abort wins.

Optional Feature:
Macro GAUSS_SEQ_STATS_EN.
- Defined:
  - adds output ready_cnt (ADDR_W+1 bits), which counts filt_ready_in strobes in the current frame;
  - ready_cnt clears when leaving WAIT_VS and holds its value after DONE;
  - adds output cnt_mismatch, a one-cycle pulse in DONE when ready_cnt does not equal H_ACTIVE*V_ACTIVE.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Shared package gauss_seq_pkg holds:
  - the state enumeration;
  - the default frame geometry constants (320, 240, 17);
  - FRAME_PIX = H_ACTIVE*V_ACTIVE.
- One natural sub-module, gauss_seq_addr_ctr: a loadable, wrapping address counter with increment and clear. It is instantiated twice, for rd_addr and wr_addr.

Test Plan:
All scenarios use H_ACTIVE=8, V_ACTIVE=4, LINE_GAP=2, DRAIN_CYC=3.
1. rst high mid-RUN: all outputs are 0 in the same cycle (asynchronous). After release, state is IDLE and busy=0.
2. start, then a vsync edge:
   - rd_addr runs 0..31, with filt_active low for exactly 2 cycles between lines;
   - frame_done pulses at cycle 32+6+3+1 after RUN entry;
   - busy returns to 0.
3. filt_ready_in held high for 34 cycles: wr_addr runs 0..31, wraps to 0, then reaches 2.
4. vsync edge at row 2, col 5: frame_err pulses once, and rd_addr restarts at 0 on the next cycle.
5. abort and start together in WAIT_VS: state is IDLE next cycle, busy=0, no frame_done.
6. continuous=1 across two frames: after DONE the state is WAIT_VS, and the second frame's rd_addr restarts at 0. With GAUSS_SEQ_STATS_EN defined and 31 ready strobes, cnt_mismatch pulses in DONE.
